// File: rtl/keypad_pkg.sv
// Shared types and key decode table for the 4x4 matrix keypad front end.
package keypad_pkg;

  localparam logic [3:0] KEY_STAR = 4'hD;
  localparam logic [3:0] KEY_HASH = 4'hE;
  localparam logic [3:0] KEY_NONE = 4'hF;

  typedef enum logic [1:0] {
    KP_SCAN,
    KP_DEBOUNCE,
    KP_HELD,
    KP_RELEASE
  } kp_state_t;

  // Row/column position to key code; the 'D' position is reserved as "none".
  function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] column);
    logic [3:0] code;
    code = KEY_NONE;
    case ({row, column})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = KEY_STAR;
      4'hD: code = 4'h0;
      4'hE: code = KEY_HASH;
      4'hF: code = KEY_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_event_sync.sv
// Two-flop synchroniser for the asynchronous keypad rows; idles at all-ones.
module sync_2ff #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_event.sv
// Keypad scanner: column strobing, row debounce and one key_valid pulse per press.
module keypad_event
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_CYCLES     = 27_000,
  parameter int unsigned DEBOUNCE_CYCLES = 270_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] fil,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned SCAN_W = $clog2(SCAN_CYCLES) + 1;
  localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] ROWS_IDLE = 4'b1111;
  localparam logic [3:0] COL_RESET = 4'b1110;

  logic [3:0] rs;

  sync_2ff #(.WIDTH(4)) u_row_sync (
    .clk (clk),
    .rst (rst),
    .d   (fil),
    .q   (rs)
  );

  kp_state_t         state, state_nxt;
  logic [SCAN_W-1:0] scan_cnt, scan_nxt;
  logic [DEB_W-1:0]  deb_cnt, deb_nxt;
  logic [3:0]        cap_rows, cap_rows_nxt;
  logic [1:0]        cap_col, cap_col_nxt;
  logic [3:0]        col_nxt, code_nxt;
  logic              valid_nxt, held_nxt;
  logic [3:0]        dec_code;

  function automatic logic [2:0] zero_count(input logic [3:0] v);
    return 3'(!v[0]) + 3'(!v[1]) + 3'(!v[2]) + 3'(!v[3]);
  endfunction

  // Position of the lowest zero bit; callers only use it on one-zero patterns.
  function automatic logic [1:0] zero_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic [3:0] rotate_col(input logic [3:0] c);
    return {c[2:0], c[3]};
  endfunction

  always_comb begin
    state_nxt    = state;
    scan_nxt     = scan_cnt;
    deb_nxt      = deb_cnt;
    cap_rows_nxt = cap_rows;
    cap_col_nxt  = cap_col;
    col_nxt      = col;
    code_nxt     = key_code;
    valid_nxt    = 1'b0;
    held_nxt     = key_held;
    dec_code     = key_lookup(zero_index(cap_rows), cap_col);

    case (state)
      KP_SCAN: begin
        if (scan_cnt >= SCAN_LAST) begin
          scan_nxt = '0;
          if (zero_count(rs) == 3'd1) begin
            cap_rows_nxt = rs;
            cap_col_nxt  = zero_index(col);
            deb_nxt      = '0;
            state_nxt    = KP_DEBOUNCE;
          end else begin
            // No key or a ghosted multi-key pattern: keep scanning.
            col_nxt = rotate_col(col);
          end
        end else begin
          scan_nxt = scan_cnt + SCAN_W'(1);
        end
      end
      KP_DEBOUNCE: begin
        if (rs != cap_rows) begin
          scan_nxt  = '0;
          state_nxt = KP_SCAN;
        end else if (deb_cnt >= DEB_LAST) begin
          code_nxt  = dec_code;
          valid_nxt = (dec_code != KEY_NONE);
          held_nxt  = 1'b1;
          state_nxt = KP_HELD;
        end else begin
          deb_nxt = deb_cnt + DEB_W'(1);
        end
      end
      KP_HELD: begin
        if (rs == ROWS_IDLE) begin
          deb_nxt   = '0;
          state_nxt = KP_RELEASE;
        end
      end
      KP_RELEASE: begin
        if (rs != ROWS_IDLE) begin
          state_nxt = KP_HELD;
        end else if (deb_cnt >= DEB_LAST) begin
          held_nxt  = 1'b0;
          code_nxt  = KEY_NONE;
          col_nxt   = rotate_col(col);
          scan_nxt  = '0;
          state_nxt = KP_SCAN;
        end else begin
          deb_nxt = deb_cnt + DEB_W'(1);
        end
      end
      default: state_nxt = KP_SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= KP_SCAN;
      scan_cnt  <= '0;
      deb_cnt   <= '0;
      cap_rows  <= ROWS_IDLE;
      cap_col   <= 2'd0;
      col       <= COL_RESET;
      key_code  <= KEY_NONE;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_nxt;
      scan_cnt  <= scan_nxt;
      deb_cnt   <= deb_nxt;
      cap_rows  <= cap_rows_nxt;
      cap_col   <= cap_col_nxt;
      col       <= col_nxt;
      key_code  <= code_nxt;
      key_valid <= valid_nxt;
      key_held  <= held_nxt;
    end
  end

endmodule

// File: tb/tb_keypad_event.sv
// Bench for keypad_event: a keypad model closes row/column contacts and a monitor checks each event.
module tb_keypad_event;

  localparam int unsigned SCAN = 4;
  localparam int unsigned DEB  = 8;
  localparam logic [3:0] KEY_TAB [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hD, 4'h0, 4'hE, 4'hF
  };

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] fil, col, key_code;
  logic       key_valid, key_held;

  logic       pressed;
  logic [1:0] pr, pc;
  logic       ovr_en;
  logic [3:0] ovr_val;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  // Physical keypad: a pressed key pulls its row low only while its column is strobed.
  always_comb begin
    fil = 4'hF;
    if (ovr_en) fil = ovr_val;
    else if (pressed && col[pc] == 1'b0) fil = ~(4'(1) << pr);
  end

  keypad_event #(
    .SCAN_CYCLES     (SCAN),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fil       (fil),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  int         run_low  = 0;
  int         run_high = 0;
  logic [3:0] last_fil = 4'hF;
  logic       prev_held = 1'b0;
  logic [3:0] exp_code;

  // Event monitor: every pulse must match the next expected key and follow a stable press.
  always @(negedge clk) begin
    if (rst) begin
      if (key_valid) begin
        pulses++;
        checks++;
        if (key_held !== 1'b1) begin
          errors++;
          $display("FAIL pulse_held: key_held=%0b required 1", key_held);
        end
        checks++;
        if (run_low < int'(DEB + 3) || run_low > int'(DEB + 4)) begin
          errors++;
          $display("FAIL pulse_latency: rows stable %0d cycles, required %0d..%0d", run_low, DEB + 3, DEB + 4);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_pulse: key_code=%h, required no pulse", key_code);
        end else begin
          exp_code = exp_q.pop_front();
          if (key_code !== exp_code) begin
            errors++;
            $display("FAIL pulse_code: key_code=%h required %h", key_code, exp_code);
          end
        end
      end
      if (prev_held && !key_held) begin
        checks++;
        if (run_high != int'(DEB + 3)) begin
          errors++;
          $display("FAIL release_latency: rows idle %0d cycles, required %0d", run_high, DEB + 3);
        end
      end
      if (!key_held) begin
        checks++;
        if (key_code !== 4'hF) begin
          errors++;
          $display("FAIL idle_code: key_code=%h required f", key_code);
        end
      end
      prev_held = key_held;
    end else begin
      prev_held = 1'b0;
    end
    if (fil == 4'hF) begin
      run_high++;
      run_low = 0;
    end else begin
      run_high = 0;
      run_low  = (fil == last_fil) ? run_low + 1 : 1;
    end
    last_fil = fil;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic press(input logic [1:0] r, input logic [1:0] c);
    pr = r;
    pc = c;
    pressed = 1'b1;
    if (KEY_TAB[{r, c}] != 4'hF) exp_q.push_back(KEY_TAB[{r, c}]);
  endtask

  task automatic test_reset();
    logic [3:0] exp_col;
    rst = 1'b0; pressed = 1'b0; ovr_en = 1'b0; ovr_val = 4'hF; pr = 2'd0; pc = 2'd0;
    step(3);
    checks++; if (col !== 4'b1110) begin errors++; $display("FAIL reset_col: col=%b required 1110", col); end
    checks++; if (key_code !== 4'hF) begin errors++; $display("FAIL reset_code: key_code=%h required f", key_code); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: key_valid=%b required 0", key_valid); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL reset_held: key_held=%b required 0", key_held); end
    rst = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step(SCAN);
      exp_col = ~(4'(1) << (i % 4));
      checks++;
      if (col !== exp_col) begin errors++; $display("FAIL scan_rotate: col=%b required %b", col, exp_col); end
    end
  endtask

  task automatic test_single();
    press(2'd1, 2'd1);
    step(40);
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL single_held: key_held=%b required 1", key_held); end
    checks++; if (key_code !== 4'h5) begin errors++; $display("FAIL single_code: key_code=%h required 5", key_code); end
    pressed = 1'b0;
    step(20);
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL single_release: key_held=%b required 0", key_held); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL single_missing: %0d pulses outstanding, required 0", exp_q.size()); end
  endtask

  task automatic test_star_hash();
    int p0;
    p0 = pulses;
    press(2'd3, 2'd0);
    step(40);
    pressed = 1'b0;
    step(20);
    press(2'd3, 2'd2);
    step(40);
    pressed = 1'b0;
    step(20);
    checks++; if (pulses != p0 + 2) begin errors++; $display("FAIL star_hash_count: %0d pulses required %0d", pulses - p0, 2); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL star_hash_missing: %0d outstanding, required 0", exp_q.size()); end
  endtask

  task automatic test_bounce();
    int p0;
    p0 = pulses;
    pr = 2'd2;
    pc = 2'd2;
    for (int i = 0; i < 5; i++) begin
      pressed = 1'b1;
      step(3);
      pressed = 1'b0;
      step(3);
    end
    checks++; if (pulses != p0) begin errors++; $display("FAIL bounce_quiet: %0d pulses required 0", pulses - p0); end
    press(2'd2, 2'd2);
    step(40);
    checks++; if (pulses != p0 + 1) begin errors++; $display("FAIL bounce_stable: %0d pulses required 1", pulses - p0); end
    pressed = 1'b0;
    step(20);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bounce_missing: %0d outstanding, required 0", exp_q.size()); end
  endtask

  task automatic test_hold_glitch();
    int p0;
    p0 = pulses;
    press(2'd2, 2'd1);
    step(40);
    for (int i = 0; i < 8; i++) begin
      step(20);
      pressed = 1'b0;
      step(2);
      pressed = 1'b1;
    end
    step(20);
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL glitch_held: key_held=%b required 1", key_held); end
    checks++; if (pulses != p0 + 1) begin errors++; $display("FAIL glitch_count: %0d pulses required 1", pulses - p0); end
    pressed = 1'b0;
    step(20);
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL glitch_release: key_held=%b required 0", key_held); end
  endtask

  task automatic test_ghost_and_d();
    int p0;
    p0 = pulses;
    ovr_val = 4'b1100;
    ovr_en = 1'b1;
    step(60);
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL ghost_held: key_held=%b required 0", key_held); end
    ovr_en = 1'b0;
    step(20);
    press(2'd3, 2'd3);
    step(40);
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL d_held: key_held=%b required 1", key_held); end
    checks++; if (pulses != p0) begin errors++; $display("FAIL ghost_d_pulses: %0d pulses required 0", pulses - p0); end
    pressed = 1'b0;
    step(20);
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL d_release: key_held=%b required 0", key_held); end
  endtask

  task automatic test_reset_held();
    int p0;
    int waited;
    p0 = pulses;
    press(2'd2, 2'd1);
    waited = 0;
    while (key_held !== 1'b1 && waited < 100) begin
      step(1);
      waited++;
    end
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL rst_held_timeout: key_held=%b required 1", key_held); end
    step(5);
    rst = 1'b0;
    #1;
    checks++; if (col !== 4'b1110) begin errors++; $display("FAIL rst_mid_col: col=%b required 1110", col); end
    checks++; if (key_code !== 4'hF) begin errors++; $display("FAIL rst_mid_code: key_code=%h required f", key_code); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL rst_mid_held: key_held=%b required 0", key_held); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: key_valid=%b required 0", key_valid); end
    step(3);
    rst = 1'b1;
    exp_q.push_back(4'h8);
    step(50);
    checks++; if (pulses != p0 + 2) begin errors++; $display("FAIL rst_redetect: %0d pulses required 2", pulses - p0); end
    pressed = 1'b0;
    step(20);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rst_missing: %0d outstanding, required 0", exp_q.size()); end
  endtask

  task automatic test_random();
    logic [1:0] r, c;
    for (int i = 0; i < 12; i++) begin
      r = 2'($urandom_range(0, 3));
      c = 2'($urandom_range(0, 3));
      press(r, c);
      step(int'($urandom_range(40, 70)));
      checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL rand_held: key r%0d c%0d key_held=%b required 1", r, c, key_held); end
      pressed = 1'b0;
      step(int'($urandom_range(25, 45)));
      checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL rand_release: key r%0d c%0d key_held=%b required 0", r, c, key_held); end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_missing: %0d outstanding, required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_star_hash();
    test_bounce();
    test_hold_glitch();
    test_ghost_and_d();
    test_reset_held();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
